// File: rtl/Pipe_Buf_Reg_PKG.sv
// Pipeline buffer register payloads plus MEM-stage state and func3 encodings.
package Pipe_Buf_Reg_PKG;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned FUNC3_W    = 3;

  typedef struct packed {
    logic                  RegWrite;
    logic                  MemtoReg;
    logic                  MemRead;
    logic                  MemWrite;
    logic                  haltInsert;
    logic [FUNC3_W-1:0]    func3;
    logic [XLEN-1:0]       MUX_final;
    logic [XLEN-1:0]       Pc_Imm;
    logic [XLEN-1:0]       Pc_Four;
    logic [XLEN-1:0]       Imm_Out;
    logic [XLEN-1:0]       Alu_Result;
    logic [XLEN-1:0]       RD_Two;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       Curr_Instr;
  } ex_mem_reg;

  typedef struct packed {
    logic                  RegWrite;
    logic                  MemtoReg;
    logic                  haltInsert;
    logic [XLEN-1:0]       MemReadData;
    logic [XLEN-1:0]       MUX_final;
    logic [XLEN-1:0]       Pc_Imm;
    logic [XLEN-1:0]       Pc_Four;
    logic [XLEN-1:0]       Imm_Out;
    logic [XLEN-1:0]       Alu_Result;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       Curr_Instr;
  } mem_wb_reg;

  typedef enum logic [1:0] {
    MEM_IDLE   = 2'd0,
    MEM_WAIT   = 2'd1,
    MEM_HALTED = 2'd2
  } mem_state_e;

  localparam logic [FUNC3_W-1:0] F3_B  = 3'b000;
  localparam logic [FUNC3_W-1:0] F3_H  = 3'b001;
  localparam logic [FUNC3_W-1:0] F3_W  = 3'b010;
  localparam logic [FUNC3_W-1:0] F3_BU = 3'b100;
  localparam logic [FUNC3_W-1:0] F3_HU = 3'b101;

endpackage

// File: rtl/load_store_align.sv
// Combinational store lane steering, load lane extraction/extension and alignment check.
module load_store_align
  import Pipe_Buf_Reg_PKG::*;
(
  input  logic [FUNC3_W-1:0] func3,
  input  logic [1:0]         off,
  input  logic [XLEN-1:0]    rd_two,
  input  logic [XLEN-1:0]    rdata,
  output logic               aligned,
  output logic [3:0]         be,
  output logic [XLEN-1:0]    wdata,
  output logic [XLEN-1:0]    load_data
);

  logic [XLEN-1:0] shifted;

  // Access size comes from func3[1:0]; a halfword may sit anywhere it fits in the word.
  always_comb begin
    aligned = 1'b0;
    be      = 4'b0000;
    wdata   = '0;
    case (func3[1:0])
      2'b00: begin
        aligned = 1'b1;
        be      = 4'b0001 << off;
        wdata   = {4{rd_two[7:0]}};
      end
      2'b01: begin
        aligned = (off != 2'd3);
        be      = 4'b0011 << off;
        wdata   = {2{rd_two[15:0]}};
      end
      default: begin
        aligned = (off == 2'd0);
        be      = 4'b1111;
        wdata   = rd_two;
      end
    endcase
  end

  assign shifted = rdata >> {off, 3'b000};

  always_comb begin
    load_data = rdata;
    case (func3)
      F3_B:    load_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      F3_H:    load_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      F3_BU:   load_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
      F3_HU:   load_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: data-memory req/ack handshake, load formatting, MEM/WB register, halt.
module mem_stage
  import Pipe_Buf_Reg_PKG::*;
#(
  parameter int unsigned DMEM_ADDR_W = 9
) (
  input  logic                   clk,
  input  logic                   reset,
  input  ex_mem_reg              ex_mem,
  output mem_wb_reg              mem_wb,
  output logic                   stall,
  output logic                   dmem_req,
  output logic                   dmem_we,
  output logic [DMEM_ADDR_W-1:0] dmem_addr,
  output logic [3:0]             dmem_be,
  output logic [XLEN-1:0]        dmem_wdata,
  input  logic                   dmem_ack,
  input  logic [XLEN-1:0]        dmem_rdata,
  output logic                   halted,
  output logic                   misalign_err,
  output logic [31:0]            stall_cycles
);

  mem_state_e      state, state_nxt;
  mem_wb_reg       wb_nxt;
  logic            access;
  logic            aligned;
  logic            misalign_set;
  logic [3:0]      st_be;
  logic [XLEN-1:0] st_wdata;
  logic [XLEN-1:0] ld_data;

  load_store_align u_align (
    .func3     (ex_mem.func3),
    .off       (ex_mem.Alu_Result[1:0]),
    .rd_two    (ex_mem.RD_Two),
    .rdata     (dmem_rdata),
    .aligned   (aligned),
    .be        (st_be),
    .wdata     (st_wdata),
    .load_data (ld_data)
  );

  assign access     = ex_mem.MemRead | ex_mem.MemWrite;
  assign dmem_we    = dmem_req & ex_mem.MemWrite;
  assign dmem_addr  = ex_mem.Alu_Result[DMEM_ADDR_W+1:2];
  assign dmem_be    = ex_mem.MemWrite ? st_be : 4'b1111;
  assign dmem_wdata = st_wdata;

  always_ff @(posedge clk) begin
    if (reset) state <= MEM_IDLE;
    else       state <= state_nxt;
  end

  // Next state, handshake outputs and the MEM/WB value to capture at the next edge.
  always_comb begin
    state_nxt    = state;
    dmem_req     = 1'b0;
    stall        = 1'b0;
    misalign_set = 1'b0;
    wb_nxt       = '0;
    case (state)
      MEM_IDLE, MEM_WAIT: begin
        dmem_req     = access & aligned & ~reset;
        stall        = dmem_req & ~dmem_ack;
        misalign_set = access & ~aligned;
        if (stall) begin
          state_nxt = MEM_WAIT;
        end else begin
          wb_nxt.RegWrite    = ex_mem.RegWrite & ~misalign_set;
          wb_nxt.MemtoReg    = ex_mem.MemtoReg;
          wb_nxt.haltInsert  = ex_mem.haltInsert;
          wb_nxt.MemReadData = (ex_mem.MemRead & aligned) ? ld_data : '0;
          wb_nxt.MUX_final   = ex_mem.MUX_final;
          wb_nxt.Pc_Imm      = ex_mem.Pc_Imm;
          wb_nxt.Pc_Four     = ex_mem.Pc_Four;
          wb_nxt.Imm_Out     = ex_mem.Imm_Out;
          wb_nxt.Alu_Result  = ex_mem.Alu_Result;
          wb_nxt.rd          = ex_mem.rd;
          wb_nxt.Curr_Instr  = ex_mem.Curr_Instr;
          state_nxt          = ex_mem.haltInsert ? MEM_HALTED : MEM_IDLE;
        end
      end
      MEM_HALTED: state_nxt = MEM_HALTED;
      default:    state_nxt = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_wb       <= '0;
      halted       <= 1'b0;
      misalign_err <= 1'b0;
      stall_cycles <= '0;
    end else begin
      mem_wb <= wb_nxt;
      if (wb_nxt.haltInsert) halted       <= 1'b1;
      if (misalign_set)      misalign_err <= 1'b1;
      if (stall)             stall_cycles <= stall_cycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage; the bench plays the data memory and keeps a transaction model.
module tb_mem_stage;
  import Pipe_Buf_Reg_PKG::*;

  logic        clk;
  logic        reset;
  ex_mem_reg   ex_mem;
  mem_wb_reg   mem_wb;
  logic        stall, dmem_req, dmem_we, dmem_ack;
  logic [8:0]  dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata, dmem_rdata;
  logic        halted, misalign_err;
  logic [31:0] stall_cycles;

  mem_stage #(.DMEM_ADDR_W(9)) dut (
    .clk(clk), .reset(reset), .ex_mem(ex_mem), .mem_wb(mem_wb), .stall(stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .halted(halted), .misalign_err(misalign_err), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    mem_wb_reg   wb;
    logic        halted;
    logic        mis;
    logic [31:0] sc;
  } exp_t;

  int          checks = 0;
  int          failures = 0;
  exp_t        exp_q[$];
  exp_t        cmp_e;
  logic [31:0] mem [512];
  bit          m_hlt, m_halted, m_mis;
  logic [31:0] m_sc;

  task automatic chk1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, req, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic chkwb(input string name, input mem_wb_reg act, input mem_wb_reg req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  // Gather the accessed bytes in order, then extend the top one for signed loads.
  function automatic logic [31:0] load_value(input logic [2:0] f3, input int off, input logic [31:0] w);
    int          sz;
    logic [31:0] v;
    sz = size_of(f3);
    v  = '0;
    for (int k = 0; k < sz; k++) v[8*k +: 8] = w[8*(off+k) +: 8];
    if (sz < 4 && !f3[2] && v[8*sz-1])
      for (int k = sz; k < 4; k++) v[8*k +: 8] = 8'hFF;
    return v;
  endfunction

  // One clock: apply inputs, check handshake outputs, advance the model, queue the MEM/WB expectation.
  task automatic step(input bit rst, input ex_mem_reg em, input bit ack, input logic [31:0] rd);
    int          off, sz, a;
    bit          acc, al, req, stl;
    logic [3:0]  be_m;
    logic [31:0] wd_m;
    mem_wb_reg   wb;
    exp_t        e;
    @(negedge clk);
    reset = rst; ex_mem = em; dmem_ack = ack; dmem_rdata = rd;
    #1;
    off = int'(em.Alu_Result % 32'd4);
    sz  = size_of(em.func3);
    a   = int'((em.Alu_Result / 32'd4) % 32'd512);
    acc = em.MemRead || em.MemWrite;
    al  = (off + sz) <= 4;
    req = !rst && !m_hlt && acc && al;
    stl = req && !ack;
    chk1("dmem_req", dmem_req, req);
    chk1("stall", stall, stl);
    if (rst || req) chk1("dmem_we", dmem_we, req && em.MemWrite);
    be_m = 4'hF;
    wd_m = '0;
    if (em.MemWrite)
      for (int i = 0; i < 4; i++) begin
        be_m[i]         = (i >= off) && (i < off + sz);
        wd_m[8*i +: 8]  = em.RD_Two[8*(i % sz) +: 8];
      end
    if (req) begin
      chk32("dmem_addr", 32'(dmem_addr), 32'(a));
      chk32("dmem_be", 32'(dmem_be), 32'(be_m));
      if (em.MemWrite) chk32("dmem_wdata", dmem_wdata, wd_m);
    end
    wb = '0;
    if (rst) begin
      m_hlt = 0; m_halted = 0; m_mis = 0; m_sc = '0;
    end else begin
      if (stl) m_sc = m_sc + 32'd1;
      if (!m_hlt && acc && !al) m_mis = 1;
      if (!m_hlt && !stl) begin
        wb.RegWrite    = em.RegWrite && !(acc && !al);
        wb.MemtoReg    = em.MemtoReg;
        wb.haltInsert  = em.haltInsert;
        wb.MemReadData = (em.MemRead && al) ? load_value(em.func3, off, rd) : 32'd0;
        wb.MUX_final   = em.MUX_final;
        wb.Pc_Imm      = em.Pc_Imm;
        wb.Pc_Four     = em.Pc_Four;
        wb.Imm_Out     = em.Imm_Out;
        wb.Alu_Result  = em.Alu_Result;
        wb.rd          = em.rd;
        wb.Curr_Instr  = em.Curr_Instr;
        if (em.haltInsert) m_hlt = 1;
      end
      if (wb.haltInsert) m_halted = 1;
      if (req && ack && em.MemWrite)
        for (int i = 0; i < 4; i++)
          if (be_m[i]) mem[a][8*i +: 8] = wd_m[8*i +: 8];
    end
    e.wb = wb; e.halted = m_halted; e.mis = m_mis; e.sc = m_sc;
    exp_q.push_back(e);
  endtask

  // Present one instruction; the memory acks after lat wait cycles if a request is due.
  task automatic run_instr(input ex_mem_reg em, input int lat);
    int off, a;
    bit req;
    off = int'(em.Alu_Result % 32'd4);
    a   = int'((em.Alu_Result / 32'd4) % 32'd512);
    req = !m_hlt && (em.MemRead || em.MemWrite) && (off + size_of(em.func3) <= 4);
    if (!req) step(1'b0, em, 1'b0, $urandom);
    else
      for (int c = 0; c <= lat; c++)
        step(1'b0, em, c == lat, (c == lat) ? mem[a] : $urandom);
  endtask

  function automatic ex_mem_reg rand_em();
    ex_mem_reg em;
    int        k;
    em.RegWrite   = 1'($urandom);
    em.MemtoReg   = 1'($urandom);
    em.haltInsert = 1'b0;
    em.func3      = 3'($urandom);
    em.MUX_final  = $urandom;
    em.Pc_Imm     = $urandom;
    em.Pc_Four    = $urandom;
    em.Imm_Out    = $urandom;
    em.RD_Two     = $urandom;
    em.rd         = 5'($urandom);
    em.Curr_Instr = $urandom;
    em.Alu_Result = $urandom;
    em.Alu_Result[10:5] = 6'd0;
    if ($urandom_range(0, 1) == 1) em.Alu_Result[1:0] = 2'b00;
    k = $urandom_range(0, 3);
    em.MemRead  = (k == 1);
    em.MemWrite = (k == 2);
    return em;
  endfunction

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      cmp_e = exp_q.pop_front();
      chkwb("mem_wb", mem_wb, cmp_e.wb);
      chk1("halted", halted, cmp_e.halted);
      chk1("misalign_err", misalign_err, cmp_e.mis);
      chk32("stall_cycles", stall_cycles, cmp_e.sc);
    end
  end

  initial begin
    ex_mem_reg em;
    reset = 1'b1; ex_mem = '0; dmem_ack = 1'b0; dmem_rdata = '0;
    m_hlt = 0; m_halted = 0; m_mis = 0; m_sc = '0;
    for (int i = 0; i < 512; i++) mem[i] = $urandom;

    step(1'b1, '0, 1'b0, '0);
    step(1'b1, '0, 1'b0, '0);
    after_edge();
    chkwb("reset_mem_wb", mem_wb, '0);
    chk32("reset_stall_cycles", stall_cycles, 32'd0);
    chk1("reset_halted", halted, 1'b0);
    chk1("reset_misalign", misalign_err, 1'b0);

    // LW zero-wait
    mem[4] = 32'hDEADBEEF;
    em = '0; em.MemRead = 1'b1; em.RegWrite = 1'b1; em.func3 = F3_W; em.Alu_Result = 32'h10; em.rd = 5'd3;
    step(1'b0, em, 1'b1, mem[4]);
    chk32("lw_addr", 32'(dmem_addr), 32'd4);
    chk1("lw_no_stall", stall, 1'b0);
    after_edge();
    chk32("lw_data", mem_wb.MemReadData, 32'hDEADBEEF);

    // LB off=3, ack after three wait cycles
    mem[8] = 32'h80FF0000;
    em = '0; em.MemRead = 1'b1; em.RegWrite = 1'b1; em.func3 = F3_B; em.Alu_Result = 32'h23; em.rd = 5'd4;
    for (int c = 0; c < 3; c++) begin
      step(1'b0, em, 1'b0, $urandom);
      chk1("lb_stall", stall, 1'b1);
    end
    step(1'b0, em, 1'b1, mem[8]);
    after_edge();
    chk32("lb_data", mem_wb.MemReadData, 32'hFFFFFF80);
    chk32("lb_stall_cycles", stall_cycles, 32'd3);

    // SH off=2, one wait cycle
    em = '0; em.MemWrite = 1'b1; em.func3 = F3_H; em.Alu_Result = 32'h22; em.RD_Two = 32'h1234ABCD;
    step(1'b0, em, 1'b0, $urandom);
    chk32("sh_be", 32'(dmem_be), 32'hC);
    chk32("sh_wdata", dmem_wdata, 32'hABCDABCD);
    chk1("sh_we", dmem_we, 1'b1);
    step(1'b0, em, 1'b1, mem[8]);
    after_edge();
    chk32("sh_readdata", mem_wb.MemReadData, 32'd0);

    // Misaligned LW
    em = '0; em.MemRead = 1'b1; em.RegWrite = 1'b1; em.func3 = F3_W; em.Alu_Result = 32'h31;
    step(1'b0, em, 1'b0, $urandom);
    chk1("mis_no_req", dmem_req, 1'b0);
    after_edge();
    chk1("mis_regwrite", mem_wb.RegWrite, 1'b0);
    chk1("mis_err", misalign_err, 1'b1);
    run_instr('0, 0);
    chk1("mis_sticky", misalign_err, 1'b1);

    for (int n = 0; n < 400; n++) run_instr(rand_em(), $urandom_range(0, 3));

    // Reset in the second WAIT cycle
    em = '0; em.MemRead = 1'b1; em.RegWrite = 1'b1; em.func3 = F3_W; em.Alu_Result = 32'h40;
    step(1'b0, em, 1'b0, $urandom);
    step(1'b0, em, 1'b0, $urandom);
    step(1'b1, em, 1'b0, $urandom);
    chk1("rst_wait_req", dmem_req, 1'b0);
    after_edge();
    chkwb("rst_wait_mem_wb", mem_wb, '0);
    chk32("rst_wait_stall_cycles", stall_cycles, 32'd0);
    chk1("rst_wait_misalign", misalign_err, 1'b0);
    step(1'b0, em, 1'b1, mem[16]);
    chk1("rst_idle_no_stall", stall, 1'b0);

    // Halt on a non-access instruction
    em = '0; em.haltInsert = 1'b1; em.RegWrite = 1'b1; em.rd = 5'd7;
    run_instr(em, 0);
    after_edge();
    chk1("halt_wb_flag", mem_wb.haltInsert, 1'b1);
    chk1("halt_halted", halted, 1'b1);
    em = '0; em.MemRead = 1'b1; em.func3 = F3_W; em.Alu_Result = 32'h44;
    run_instr(em, 0);
    chk1("halt_no_req", dmem_req, 1'b0);
    after_edge();
    chkwb("halt_bubble", mem_wb, '0);
    for (int n = 0; n < 5; n++) run_instr(rand_em(), 1);

    // Halt carried by a load: the access completes first
    step(1'b1, '0, 1'b0, '0);
    mem[20] = 32'h11223344;
    em = '0; em.MemRead = 1'b1; em.haltInsert = 1'b1; em.func3 = F3_W; em.Alu_Result = 32'h50;
    run_instr(em, 2);
    after_edge();
    chk32("halt_load_data", mem_wb.MemReadData, 32'h11223344);
    chk1("halt_load_halted", halted, 1'b1);
    for (int n = 0; n < 5; n++) run_instr(rand_em(), 1);

    after_edge();
    after_edge();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Pipeline MEM stage between the EX/MEM register and the MEM/WB register. It consumes an `ex_mem_reg`, performs the load or store against a variable-latency data memory through a req/ack handshake, and formats byte, halfword and word data. It stalls upstream while an access is outstanding and produces the registered `mem_wb_reg` consumed by writeback. It also terminates the pipeline on `haltInsert`.

## Interface
- `DMEM_ADDR_W`, default 9: word-address width of the data memory.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `ex_mem`  in  `ex_mem_reg`  EX/MEM register contents; held stable by upstream while `stall` = 1.
- `mem_wb`  out  `mem_wb_reg`  registered MEM/WB contents.
- `stall`  out  1  combinational; freezes PC, IF/ID, ID/EX and EX/MEM.
- `dmem_req`  out  1  access request.
- `dmem_we`  out  1  1 = store, 0 = load.
- `dmem_addr`  out  `DMEM_ADDR_W`  word address, `Alu_Result[DMEM_ADDR_W+1:2]`.
- `dmem_be`  out  4  byte enables (store lanes; 4'b1111 for loads).
- `dmem_wdata`  out  32  lane-aligned store data.
- `dmem_ack`  in  1  access complete; for loads `dmem_rdata` is valid in the same cycle.
- `dmem_rdata`  in  32  read word.
- `halted`  out  1  set once a halt reaches MEM/WB.
- `misalign_err`  out  1  sticky; set on a misaligned access.
- `stall_cycles`  out  32  count of cycles with `stall` = 1; wraps.

## Operation
- **access** = `MemRead | MemWrite`; **aligned** = (`func3[1:0]`=00) | (`func3[1:0]`=01 & off≠3) | (`func3[1:0]`=1x & off=0), where off = `Alu_Result[1:0]`.
- **States:** IDLE, WAIT, HALTED.
  - IDLE: if access & aligned, drive `dmem_req`=1.
    - `dmem_ack`=1 → complete.
    - Otherwise → WAIT.
  - WAIT: keep `dmem_req`=1 with identical signals until `dmem_ack`; on ack → IDLE.
  - A non-stalled cycle with `haltInsert`=1 → HALTED.
  - HALTED: exits only via reset.
- `stall` = (state∈{IDLE,WAIT}) & access & aligned & ~`dmem_ack` & ~`reset`. `dmem_req` is forced 0 while `reset`=1 or in HALTED.
- **Store lanes:**
  - SB: be = 1<<off, wdata = {4{RD_Two[7:0]}}.
  - SH: be = 0011<<off, wdata = {2{RD_Two[15:0]}}.
  - SW: be = 1111, wdata = RD_Two.
- **Load format** (func3): lanes are selected by off.
  - 000 = LB, sign-extended.
  - 001 = LH, sign-extended.
  - 100 = LBU, zero-extended.
  - 101 = LHU, zero-extended.
  - All other codes are treated as LW.
- **Misaligned access:** no request is issued and no stall occurs. `misalign_err` is set. The instruction passes to MEM/WB with RegWrite=0.
- **mem_wb update:**
  - Non-stalled cycle: copy RegWrite, MemtoReg, haltInsert, MUX_final, Pc_Imm, Pc_Four, Imm_Out, Alu_Result, rd and Curr_Instr from `ex_mem`. MemReadData = formatted load (0 for non-loads).
  - Stalled cycle or HALTED: load a bubble (all fields 0).
- `halted` is set on the edge where `mem_wb.haltInsert` becomes 1.

## Timing
- **Reset:** `mem_wb`=0, state=IDLE, `halted`=0, `misalign_err`=0, `stall_cycles`=0. `dmem_req`, `stall` and `dmem_we` are 0 during the reset cycle.
- **Zero-wait access** (ack in the request cycle): 1-cycle MEM, no stall, result in `mem_wb` at the next edge.
- **N-cycle ack:** `stall` is high for N cycles and `mem_wb` receives N bubbles. The result lands on the edge after ack.
- **Reset mid-WAIT:** the access is abandoned and `dmem_req` drops in the reset cycle. The memory must tolerate a dropped request.
- **Halt and access in the same instruction:** the access completes first, then the FSM enters HALTED.
- **`stall_cycles`:** increments on each edge where `stall`=1 and wraps from 0xFFFFFFFF to 0.

## Structure
- `mem_wb_reg` and `ex_mem_reg` come from `Pipe_Buf_Reg_PKG`.
- Add to the package:
  - the state enum `mem_state_e`;
  - the func3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
- Sub-module `load_store_align`: combinational store lane steering, load extraction/extension and alignment check.
- `mem_stage` holds the FSM, the MEM/WB register and the counters.

## Test plan
- LW, `Alu_Result`=0x10, ack same cycle, rdata=0xDEADBEEF → `dmem_addr`=4, no stall, next edge `mem_wb.MemReadData`=0xDEADBEEF.
- LB off=3, rdata=0x80FF_0000, ack after 3 cycles → `stall` high 3 cycles, 3 bubbles, then MemReadData=0xFFFFFF80, `stall_cycles`=3.
- SH off=2, RD_Two=0x1234ABCD → be=4'b1100, wdata=0xABCDABCD, we=1, `mem_wb.MemReadData`=0.
- LW off=1 → no `dmem_req`, `misalign_err`=1 sticky, `mem_wb.RegWrite`=0, no stall.
- Reset asserted in the second WAIT cycle → `dmem_req`=0 that cycle, all outputs zero after the edge, state IDLE.
- haltInsert=1 on a non-access instruction → `mem_wb.haltInsert`=1, `halted`=1 next edge; later loads produce no `dmem_req` and `mem_wb` stays 0.
